lrsc_arbiter: RTL and testbench
===============================

// Module: lrsc_arbiter
// PURPOSE
//  Shares one data-memory port between NUM_HARTS hart request channels using round-robin grant.
//  Owns per-hart LR/SC reservation state (valid + address per hart).
//  Qualifies each store-conditional: an SC writes memory only on success.
//  Returns a registered SC result to the issuing hart. Sits between the hart
//  load/store issue logic and the data BRAM port.
// PARAMETERS
//  NUM_HARTS       4    number of requesting harts (>=2, power of two)
//  ADDR_W          12   word address width
//  TIMEOUT_CYCLES  64   reservation lifetime in cycles (used only with LRSC_TIMEOUT_EN)
// PORTS
//  clk            in   1                  clock
//  reset          in   1                  sync active-high reset
//  i_req          in   NUM_HARTS          per-hart request valid
//  i_req_op       in   2*NUM_HARTS        per-hart op: 00 LOAD, 01 STORE, 10 LR, 11 SC
//  i_req_addr     in   ADDR_W*NUM_HARTS   per-hart word address
//  o_gnt          out  NUM_HARTS          one-hot grant, combinational
//  o_mem_addr     out  ADDR_W             address of granted request, combinational
//  o_mem_we       out  1                  write enable: STORE, or SC that succeeds
//  o_mem_hart     out  $clog2(NUM_HARTS)  index of granted hart
//  o_resp_valid   out  1                  registered, one cycle after any grant
//  o_resp_hart    out  $clog2(NUM_HARTS)  registered hart index of response
//  o_sc_success   out  1                  registered; 1 = SC succeeded (0 for non-SC ops)
// BEHAVIOUR
//  Reset:
//   - rr_ptr=0; all rsv_valid=0.
//   - o_resp_valid, o_resp_hart and o_sc_success = 0.
//   - rsv_addr is not reset.
//  Arbitration:
//   - Scan harts from rr_ptr upward, wrapping modulo NUM_HARTS. The first requesting hart gets gnt.
//   - At most one grant per cycle.
//   - No request: o_gnt=0, o_mem_we=0, rr_ptr holds.
//   - On grant to hart g: rr_ptr <= (g+1) mod NUM_HARTS.
//  Handshake:
//   - A hart holds req/op/addr stable until it sees gnt=1.
//   - Op and address are consumed in the grant cycle.
//   - Deasserting before grant is legal; nothing is recorded.
//  Reservation updates (granted hart g, address A; applied at the clock edge):
//   - LR: rsv_valid[g]<=1, rsv_addr[g]<=A. Overwrites any older reservation of g.
//   - STORE: every hart h with rsv_valid[h] and rsv_addr[h]==A is cleared, including g.
//   - SC success: combinational, sc_ok = rsv_valid[g] && rsv_addr[g]==A.
//   - SC, always: rsv_valid[g]<=0.
//   - SC, if sc_ok: o_mem_we=1 and other harts matching A are cleared, as for a STORE.
//   - LOAD: no reservation change.
//  Response:
//   - Next cycle o_resp_valid=1, o_resp_hart=g, o_sc_success=sc_ok when op was SC, else 0.
//   - Latency is 1 cycle.
//  Boundary cases:
//   - rr_ptr wraps from NUM_HARTS-1 to 0.
//   - Same-cycle LR by g and a pending store by another hart cannot occur, because only one grant is issued.
//   - An SC with no prior LR fails with no write.
//   - Reset mid-operation drops the pending response and all reservations.
// CONFIGURATION
//  LRSC_TIMEOUT_EN defined:
//   - Each hart has a counter, loaded with TIMEOUT_CYCLES-1 on its LR and decremented each cycle while rsv_valid.
//   - At 0, rsv_valid clears. An SC granted in that same cycle fails.
//   - A new LR reloads the counter.
//  LRSC_TIMEOUT_EN undefined:
//   - No counters; reservations live until a STORE, SC or reset clears them.
//   - TIMEOUT_CYCLES is ignored.
// TESTING
//  1 Reset, then hart0 LR 0x010 and next hart0 SC 0x010
//    -> SC cycle mem_we=1; next cycle resp_hart=0, sc_success=1.
//  2 hart1 LR 0x020; hart2 STORE 0x020; hart1 SC 0x020
//    -> SC mem_we=0, sc_success=0.
//  3 All 4 harts request every cycle from reset
//    -> gnt sequence 0001,0010,0100,1000,0001 (wrap).
//  4 hart0 LR 0x030, hart3 LR 0x030; hart0 SC 0x030 succeeds
//    -> hart3 reservation cleared, hart3 SC 0x030 fails.
//  5 hart2 SC 0x040 with no LR
//    -> mem_we=0, sc_success=0. hart2 LOAD
//    -> resp_valid=1, sc_success=0.
//  6 hart0 LR 0x050, reset pulsed 1 cycle, hart0 SC 0x050
//    -> fails. With LRSC_TIMEOUT_EN and TIMEOUT_CYCLES=8: LR, idle 8 cycles, SC
//    -> fails; SC after 3 idle cycles -> succeeds.

Source files
------------

// File: rtl/lrsc_arbiter.sv
// lrsc_arbiter: round-robin data-port arbiter with per-hart LR/SC reservations.
// Define LRSC_TIMEOUT_EN to expire each reservation TIMEOUT_CYCLES after its LR.
module lrsc_arbiter #(
  parameter int NUM_HARTS      = 4,
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_HARTS-1:0]         i_req,
  input  logic [2*NUM_HARTS-1:0]       i_req_op,
  input  logic [ADDR_W*NUM_HARTS-1:0]  i_req_addr,
  output logic [NUM_HARTS-1:0]         o_gnt,
  output logic [ADDR_W-1:0]            o_mem_addr,
  output logic                         o_mem_we,
  output logic [$clog2(NUM_HARTS)-1:0] o_mem_hart,
  output logic                         o_resp_valid,
  output logic [$clog2(NUM_HARTS)-1:0] o_resp_hart,
  output logic                         o_sc_success
);
  localparam int HW = $clog2(NUM_HARTS);
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_LR    = 2'b10;
  localparam logic [1:0] OP_SC    = 2'b11;

  if (NUM_HARTS < 2 || (NUM_HARTS & (NUM_HARTS - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("lrsc_arbiter: NUM_HARTS must be a power of two >= 2, TIMEOUT_CYCLES >= 2");
  end

  logic [HW-1:0]        rr_ptr_q, rr_ptr_d, gnt_idx;
  logic                 gnt_any;
  logic [1:0]           op;
  logic [ADDR_W-1:0]    addr;
  logic [NUM_HARTS-1:0] rsv_valid_q, rsv_valid_d, rsv_live, rsv_hit;
  logic [ADDR_W-1:0]    rsv_addr_q [NUM_HARTS];
  logic [ADDR_W-1:0]    rsv_addr_d [NUM_HARTS];
  logic                 sc_ok;
  logic                 resp_valid_q, resp_valid_d, sc_success_q, sc_success_d;
  logic [HW-1:0]        resp_hart_q, resp_hart_d;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    op      = '0;
    addr    = '0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      if (!gnt_any && i_req[rr_ptr_q + HW'(i)]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_ptr_q + HW'(i);
      end
    end
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (gnt_idx == HW'(h)) begin
        op   = i_req_op[2*h +: 2];
        addr = i_req_addr[ADDR_W*h +: ADDR_W];
      end
    end
  end

`ifdef LRSC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] rsv_cnt_q [NUM_HARTS];
  logic [CW-1:0] rsv_cnt_d [NUM_HARTS];
  // a counter sitting at zero means the reservation dies this cycle
  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      rsv_live[h]  = rsv_valid_q[h] && rsv_cnt_q[h] != '0;
      rsv_cnt_d[h] = (gnt_any && gnt_idx == HW'(h) && op == OP_LR) ? CW'(TIMEOUT_CYCLES - 1) :
                     (rsv_valid_q[h] && rsv_cnt_q[h] != '0) ? rsv_cnt_q[h] - CW'(1) : rsv_cnt_q[h];
    end
  end
  always_ff @(posedge clk) begin
    for (int h = 0; h < NUM_HARTS; h++)
      rsv_cnt_q[h] <= reset ? '0 : rsv_cnt_d[h];
  end
`else
  assign rsv_live = rsv_valid_q;
`endif

  always_comb begin
    sc_ok    = gnt_any && op == OP_SC && rsv_live[gnt_idx] && rsv_addr_q[gnt_idx] == addr;
    o_mem_we = gnt_any && (op == OP_STORE || sc_ok);
    for (int h = 0; h < NUM_HARTS; h++)
      rsv_hit[h] = rsv_live[h] && rsv_addr_q[h] == addr;
    rsv_valid_d = rsv_live & ~(o_mem_we ? rsv_hit : '0);
    rsv_addr_d  = rsv_addr_q;
    if (gnt_any && op == OP_LR) begin
      rsv_valid_d[gnt_idx] = 1'b1;
      rsv_addr_d[gnt_idx]  = addr;
    end
    if (gnt_any && op == OP_SC)
      rsv_valid_d[gnt_idx] = 1'b0;
    rr_ptr_d     = gnt_any ? gnt_idx + HW'(1) : rr_ptr_q;
    resp_valid_d = gnt_any;
    resp_hart_d  = gnt_idx;
    sc_success_d = sc_ok;
  end

  assign o_gnt        = gnt_any ? NUM_HARTS'(1) << gnt_idx : '0;
  assign o_mem_addr   = addr;
  assign o_mem_hart   = gnt_idx;
  assign o_resp_valid = resp_valid_q;
  assign o_resp_hart  = resp_hart_q;
  assign o_sc_success = sc_success_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      rsv_valid_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_hart_q  <= '0;
      sc_success_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      rsv_valid_q  <= rsv_valid_d;
      resp_valid_q <= resp_valid_d;
      resp_hart_q  <= resp_hart_d;
      sc_success_q <= sc_success_d;
    end
  end

  always_ff @(posedge clk) rsv_addr_q <= rsv_addr_d;
endmodule

// File: tb/tb_lrsc_arbiter.sv
// tb_lrsc_arbiter: directed scenarios plus randomized traffic against a reservation model.
module tb_lrsc_arbiter;
  localparam int N = 4, AW = 12, T = 8;
  logic            clk = 1'b0, reset = 1'b0;
  logic [N-1:0]    i_req = '0;
  logic [2*N-1:0]  i_req_op = '0;
  logic [AW*N-1:0] i_req_addr = '0;
  logic [N-1:0]    o_gnt;
  logic [AW-1:0]   o_mem_addr;
  logic            o_mem_we, o_resp_valid, o_sc_success;
  logic [1:0]      o_mem_hart, o_resp_hart;

  lrsc_arbiter #(.NUM_HARTS(N), .ADDR_W(AW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_req_op(i_req_op), .i_req_addr(i_req_addr),
    .o_gnt(o_gnt), .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_hart(o_mem_hart),
    .o_resp_valid(o_resp_valid), .o_resp_hart(o_resp_hart), .o_sc_success(o_sc_success));

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;
  bit m_valid [N];
  int m_addr [N];
  int m_lr_cyc [N];
  int m_ptr = 0, cyc = 0;
  logic [N-1:0]  exp_gnt, obs_gnt;
  logic          exp_we, obs_we, exp_rv, obs_rv, exp_ss, obs_ss;
  logic [1:0]    exp_hart, obs_hart, exp_rh, obs_rh;
  logic [AW-1:0] exp_addr, obs_addr;

  function automatic bit live(int h);
`ifdef LRSC_TIMEOUT_EN
    return m_valid[h] && (cyc - m_lr_cyc[h] < T);
`else
    return m_valid[h];
`endif
  endfunction

  // One clock: predict combinational and registered results, sample the DUT, advance the model.
  task automatic tick();
    int g = -1;
    int a = 0;
    logic [1:0] o = '0;
    bit ok = 0;
    #1;
    if (!reset)
      for (int i = 0; i < N; i++)
        if (g < 0 && i_req[(m_ptr + i) % N]) g = (m_ptr + i) % N;
    exp_gnt = (g < 0) ? '0 : N'(1) << g;
    exp_we = 0; exp_hart = '0; exp_addr = '0;
    if (g >= 0) begin
      o = i_req_op[2*g +: 2];
      a = int'(i_req_addr[AW*g +: AW]);
      ok = o == 2'b11 && live(g) && m_addr[g] == a;
      exp_we = o == 2'b01 || ok;
      exp_hart = g[1:0];
      exp_addr = AW'(a);
    end
    obs_gnt = o_gnt; obs_we = o_mem_we; obs_hart = o_mem_hart; obs_addr = o_mem_addr;
    if (reset) begin
      m_ptr = 0;
      for (int h = 0; h < N; h++) m_valid[h] = 0;
    end else if (g >= 0) begin
      if (exp_we)
        for (int h = 0; h < N; h++) if (m_addr[h] == a) m_valid[h] = 0;
      if (o == 2'b10) begin m_valid[g] = 1; m_addr[g] = a; m_lr_cyc[g] = cyc; end
      if (o == 2'b11) m_valid[g] = 0;
      m_ptr = (g + 1) % N;
    end
    exp_rv = g >= 0;
    exp_rh = (g >= 0) ? g[1:0] : 2'd0;
    exp_ss = ok;
    @(posedge clk);
    #1;
    obs_rv = o_resp_valid; obs_rh = o_resp_hart; obs_ss = o_sc_success;
    cyc++;
  endtask

  task automatic set_req(int h, logic [1:0] o, int a);
    i_req[h] = 1'b1;
    i_req_op[2*h +: 2] = o;
    i_req_addr[AW*h +: AW] = AW'(a);
  endtask

  task automatic one(int h, logic [1:0] o, int a);
    i_req = '0;
    set_req(h, o, a);
    tick();
    i_req = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    compared++; if (obs_rv !== 1'b0) begin mismatched++; $display("FAIL reset_resp_valid got %b want 0", obs_rv); end
    compared++; if (obs_rh !== 2'd0) begin mismatched++; $display("FAIL reset_resp_hart got %0d want 0", obs_rh); end
    compared++; if (obs_ss !== 1'b0) begin mismatched++; $display("FAIL reset_sc_success got %b want 0", obs_ss); end
    tick();
    compared++; if (obs_gnt !== 4'b0000) begin mismatched++; $display("FAIL idle_gnt got %b want 0000", obs_gnt); end
    compared++; if (obs_we !== 1'b0) begin mismatched++; $display("FAIL idle_we got %b want 0", obs_we); end
    compared++; if (obs_rv !== 1'b0) begin mismatched++; $display("FAIL idle_resp_valid got %b want 0", obs_rv); end
  endtask

  task automatic test_lr_sc();
    one(0, 2'b10, 'h010);
    compared++; if (obs_gnt !== 4'b0001) begin mismatched++; $display("FAIL lr_gnt got %b want 0001", obs_gnt); end
    compared++; if (obs_we !== 1'b0) begin mismatched++; $display("FAIL lr_we got %b want 0", obs_we); end
    one(0, 2'b11, 'h010);
    compared++; if (obs_we !== 1'b1) begin mismatched++; $display("FAIL sc_we got %b want 1", obs_we); end
    compared++; if (obs_addr !== 12'h010) begin mismatched++; $display("FAIL sc_addr got %h want 010", obs_addr); end
    compared++; if (obs_rv !== 1'b1 || obs_rh !== 2'd0) begin mismatched++; $display("FAIL sc_resp got v%b h%0d want v1 h0", obs_rv, obs_rh); end
    compared++; if (obs_ss !== 1'b1) begin mismatched++; $display("FAIL sc_success got %b want 1", obs_ss); end
  endtask

  task automatic test_store_kill();
    one(1, 2'b10, 'h020);
    one(2, 2'b01, 'h020);
    compared++; if (obs_we !== 1'b1 || obs_hart !== 2'd2) begin mismatched++; $display("FAIL store_we got we%b h%0d want we1 h2", obs_we, obs_hart); end
    one(1, 2'b11, 'h020);
    compared++; if (obs_gnt !== 4'b0010) begin mismatched++; $display("FAIL kill_gnt got %b want 0010", obs_gnt); end
    compared++; if (obs_we !== 1'b0) begin mismatched++; $display("FAIL kill_sc_we got %b want 0", obs_we); end
    compared++; if (obs_ss !== 1'b0 || obs_rh !== 2'd1) begin mismatched++; $display("FAIL kill_sc_result got s%b h%0d want s0 h1", obs_ss, obs_rh); end
  endtask

  task automatic test_rr_wrap();
    logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset = 1'b1; tick(); reset = 1'b0;
    for (int h = 0; h < N; h++) set_req(h, 2'b00, 'h100 + h);
    for (int k = 0; k < 5; k++) begin
      tick();
      compared++; if (obs_gnt !== seq[k]) begin mismatched++; $display("FAIL rr_gnt[%0d] got %b want %b", k, obs_gnt, seq[k]); end
      compared++; if (obs_we !== 1'b0 || obs_ss !== 1'b0) begin mismatched++; $display("FAIL rr_load[%0d] got we%b s%b want 0 0", k, obs_we, obs_ss); end
    end
    i_req = '0;
  endtask

  task automatic test_sc_clears_others();
    one(0, 2'b10, 'h030);
    one(3, 2'b10, 'h030);
    one(0, 2'b11, 'h030);
    compared++; if (obs_we !== 1'b1 || obs_ss !== 1'b1) begin mismatched++; $display("FAIL sc0_ok got we%b s%b want 1 1", obs_we, obs_ss); end
    one(3, 2'b11, 'h030);
    compared++; if (obs_we !== 1'b0 || obs_ss !== 1'b0) begin mismatched++; $display("FAIL sc3_killed got we%b s%b want 0 0", obs_we, obs_ss); end
    compared++; if (obs_rh !== 2'd3) begin mismatched++; $display("FAIL sc3_hart got %0d want 3", obs_rh); end
  endtask

  task automatic test_sc_no_lr();
    one(2, 2'b11, 'h040);
    compared++; if (obs_we !== 1'b0 || obs_ss !== 1'b0) begin mismatched++; $display("FAIL nolr_sc got we%b s%b want 0 0", obs_we, obs_ss); end
    one(2, 2'b00, 'h040);
    compared++; if (obs_rv !== 1'b1 || obs_ss !== 1'b0 || obs_rh !== 2'd2) begin mismatched++; $display("FAIL load_resp got v%b s%b h%0d want v1 s0 h2", obs_rv, obs_ss, obs_rh); end
  endtask

  task automatic test_reset_mid();
    one(0, 2'b10, 'h050);
    set_req(1, 2'b00, 'h051);
    reset = 1'b1; tick(); reset = 1'b0;
    i_req = '0;
    compared++; if (obs_rv !== 1'b0) begin mismatched++; $display("FAIL midrst_resp got %b want 0", obs_rv); end
    one(0, 2'b11, 'h050);
    compared++; if (obs_we !== 1'b0 || obs_ss !== 1'b0) begin mismatched++; $display("FAIL midrst_sc got we%b s%b want 0 0", obs_we, obs_ss); end
`ifdef LRSC_TIMEOUT_EN
    one(0, 2'b10, 'h060);
    repeat (8) tick();
    one(0, 2'b11, 'h060);
    compared++; if (obs_we !== 1'b0 || obs_ss !== 1'b0) begin mismatched++; $display("FAIL timeout8_sc got we%b s%b want 0 0", obs_we, obs_ss); end
    one(0, 2'b10, 'h060);
    repeat (7) tick();
    one(0, 2'b11, 'h060);
    compared++; if (obs_we !== 1'b0 || obs_ss !== 1'b0) begin mismatched++; $display("FAIL timeout7_sc got we%b s%b want 0 0", obs_we, obs_ss); end
    one(0, 2'b10, 'h060);
    repeat (6) tick();
    one(0, 2'b11, 'h060);
    compared++; if (obs_we !== 1'b1 || obs_ss !== 1'b1) begin mismatched++; $display("FAIL timeout6_sc got we%b s%b want 1 1", obs_we, obs_ss); end
    one(0, 2'b10, 'h060);
    repeat (3) tick();
    one(0, 2'b11, 'h060);
    compared++; if (obs_we !== 1'b1 || obs_ss !== 1'b1) begin mismatched++; $display("FAIL timeout3_sc got we%b s%b want 1 1", obs_we, obs_ss); end
`endif
  endtask

  task automatic test_random();
    reset = 1'b1; tick(); reset = 1'b0;
    i_req = '0;
    for (int k = 0; k < 600; k++) begin
      for (int h = 0; h < N; h++) begin
        if (!i_req[h] && $urandom_range(0, 2) == 0)
          set_req(h, 2'($urandom_range(0, 3)), 'h200 + $urandom_range(0, 3));
        else if (i_req[h] && $urandom_range(0, 15) == 0)
          i_req[h] = 1'b0;
      end
      reset = ($urandom_range(0, 99) == 0);
      tick();
      if (!reset) begin
        compared++; if (obs_gnt !== exp_gnt) begin mismatched++; $display("FAIL rnd_gnt[%0d] got %b want %b", k, obs_gnt, exp_gnt); end
        compared++; if (obs_we !== exp_we) begin mismatched++; $display("FAIL rnd_we[%0d] got %b want %b", k, obs_we, exp_we); end
        if (exp_gnt != '0) begin
          compared++; if (obs_hart !== exp_hart || obs_addr !== exp_addr) begin mismatched++; $display("FAIL rnd_port[%0d] got h%0d a%h want h%0d a%h", k, obs_hart, obs_addr, exp_hart, exp_addr); end
        end
      end
      compared++; if (obs_rv !== exp_rv || obs_ss !== exp_ss) begin mismatched++; $display("FAIL rnd_resp[%0d] got v%b s%b want v%b s%b", k, obs_rv, obs_ss, exp_rv, exp_ss); end
      if (exp_rv) begin
        compared++; if (obs_rh !== exp_rh) begin mismatched++; $display("FAIL rnd_resp_hart[%0d] got %0d want %0d", k, obs_rh, exp_rh); end
      end
      i_req = i_req & ~exp_gnt;
      reset = 1'b0;
    end
    i_req = '0;
  endtask

  initial begin
    test_reset();
    test_lr_sc();
    test_store_kill();
    test_rr_wrap();
    test_sc_clears_others();
    test_sc_no_lr();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
